// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the memory access controller: default widths,
//   the default memory-mapped I/O word address and the FSM state encoding.
package mem_access_ctrl_pkg;

   localparam int         DEF_ADDR_W  = 9;
   localparam int         DEF_DATA_W  = 32;
   localparam logic [8:0] DEF_IO_ADDR = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_CAPT  = 2'd2,
      WR_ISSUE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sits between the CPU control unit (MAR/MDR) and a 512x32 synchronous RAM
//   with a one-cycle registered read. Latches one request, drives the RAM
//   strobes from registers, and returns a single-cycle Done pulse. The word
//   at IO_ADDR is an I/O port: reads return InPort, writes load OutPort, and
//   the RAM is never strobed for it.
//
// Ports
//   Clock, Reset_n      : rising-edge clock, asynchronous active-low reset
//   Req, WrEn           : request strobe and direction (1 = write)
//   Addr, WrData        : word address and write data, latched on accept
//   RdData              : last read result, held until the next read ends
//   Busy, Done          : busy while not IDLE; one-cycle completion pulse
//   RamRead, RamWrite   : registered RAM strobes, never both high
//   RamAddr, RamDataIn  : latched address/data presented to the RAM
//   RamDataOut          : RAM read data, valid the cycle after RamRead
//   InPort, OutPort     : I/O input pins and output register
//   dbg_state           : current FSM state, for observation only
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and Req=1 (Busy=0 acts as ready). Req while Busy is dropped, not queued.
// Done high in IDLE does not block acceptance, so requests may run
// back-to-back with no bubble.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int                ADDR_W  = DEF_ADDR_W,
   parameter int                DATA_W  = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(DEF_IO_ADDR)
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Req,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WrData,
   output logic [DATA_W-1:0] RdData,
   output logic              Busy,
   output logic              Done,
   output logic              RamRead,
   output logic              RamWrite,
   output logic [ADDR_W-1:0] RamAddr,
   output logic [DATA_W-1:0] RamDataIn,
   input  logic [DATA_W-1:0] RamDataOut,
   input  logic [DATA_W-1:0] InPort,
   output logic [DATA_W-1:0] OutPort,
   output logic [1:0]        dbg_state
);

   state_t state;
   logic   is_io;

   // RamAddr/RamDataIn are themselves the latched request registers, so the
   // RAM never sees the live Addr/WrData inputs.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         is_io     <= 1'b0;
         RamAddr   <= '0;
         RamDataIn <= '0;
         RamRead   <= 1'b0;
         RamWrite  <= 1'b0;
         RdData    <= '0;
         OutPort   <= '0;
         Done      <= 1'b0;
      end else begin
         // Strobes and Done are one-cycle pulses unless re-asserted below.
         Done     <= 1'b0;
         RamRead  <= 1'b0;
         RamWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (Req) begin
                  RamAddr   <= Addr;
                  RamDataIn <= WrData;
                  is_io     <= (Addr == IO_ADDR);
                  // Strobe is raised here so it is high during the issue state.
                  if (WrEn) begin
                     state    <= WR_ISSUE;
                     RamWrite <= (Addr != IO_ADDR);
                  end else begin
                     state    <= RD_ISSUE;
                     RamRead  <= (Addr != IO_ADDR);
                  end
               end
            end
            RD_ISSUE: begin
               // RAM registers its output on this edge.
               state <= RD_CAPT;
            end
            RD_CAPT: begin
               RdData <= is_io ? InPort : RamDataOut;
               Done   <= 1'b1;
               state  <= IDLE;
            end
            WR_ISSUE: begin
               if (is_io) OutPort <= RamDataIn;
               Done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Bench for mem_access_ctrl with a behavioural 512x32 RAM (one-cycle
//   registered read) and a transaction-level reference model.
module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   localparam logic [8:0] IO = 9'h1FF;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Req = 1'b0;
   logic        WrEn = 1'b0;
   logic [8:0]  Addr = '0;
   logic [31:0] WrData = '0;
   logic [31:0] InPort = '0;
   logic [31:0] RdData, RamDataIn, RamDataOut, OutPort;
   logic [8:0]  RamAddr;
   logic        Busy, Done, RamRead, RamWrite;
   logic [1:0]  dbg_state;

   mem_access_ctrl dut (
      .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .WrEn(WrEn),
      .Addr(Addr), .WrData(WrData), .RdData(RdData), .Busy(Busy),
      .Done(Done), .RamRead(RamRead), .RamWrite(RamWrite),
      .RamAddr(RamAddr), .RamDataIn(RamDataIn), .RamDataOut(RamDataOut),
      .InPort(InPort), .OutPort(OutPort), .dbg_state(dbg_state)
   );

   always #5 Clock = ~Clock;

   // ---------------- RAM model with backdoor preload port ----------------
   logic [31:0] ram [512];
   logic [31:0] ram_dout;
   logic        bd_we = 1'b0;
   logic [8:0]  bd_addr = '0;
   logic [31:0] bd_data = '0;

   always @(posedge Clock) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (RamWrite) ram[RamAddr] <= RamDataIn;
      if (RamRead) ram_dout <= ram[RamAddr];
   end
   assign RamDataOut = ram_dout;

   // Running totals of strobe cycles and the last strobed address.
   int         rd_total = 0;
   int         wr_total = 0;
   logic [8:0] last_addr = '0;
   always @(posedge Clock) begin
      if (RamRead)  rd_total <= rd_total + 1;
      if (RamWrite) wr_total <= wr_total + 1;
      if (RamRead || RamWrite) last_addr <= RamAddr;
   end

   // ---------------- reference model and scoreboard ----------------
   logic [31:0] ref_mem [512];
   logic [31:0] ref_out = '0;
   logic [31:0] ref_rd = '0;
   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction. Starts at a negedge, ends at a negedge.
   // mode 0: drop Req after accept and scramble inputs (stability check)
   // mode 1: keep Req high with junk inputs (back-to-back, next call follows)
   // mode 2: keep Req high as a write to 0x020 while busy, then drop it
   task automatic access(input logic we, input logic [8:0] a,
                         input logic [31:0] d, input int mode);
      int          r0, w0, expn;
      logic        io;
      logic [31:0] exp_rd;
      io     = (a == IO);
      expn   = we ? 2 : 3;
      exp_rd = io ? InPort : ref_mem[a];
      r0 = rd_total;
      w0 = wr_total;
      Req = 1'b1; WrEn = we; Addr = a; WrData = d;
      @(posedge Clock); #1;
      if (mode == 2) begin
         Req = 1'b1; WrEn = 1'b1; Addr = 9'h020; WrData = 32'hBAD0BAD0;
      end else begin
         Req = (mode == 1); WrEn = 1'($urandom); Addr = 9'($urandom); WrData = $urandom;
      end
      for (int n = 1; n <= expn; n++) begin
         @(negedge Clock);
         if (mode == 2 && n == expn - 1) Req = 1'b0;
         chk("done_timing", 32'(Done), 32'(n == expn));
         if (n < expn) chk("busy", 32'(Busy), 32'd1);
      end
      if (!we) ref_rd = exp_rd;
      else if (io) ref_out = d;
      else ref_mem[a] = d;
      chk("rd_data", RdData, ref_rd);
      chk("out_port", OutPort, ref_out);
      chk("ram_read_cycles", 32'(rd_total - r0), 32'(!we && !io));
      chk("ram_write_cycles", 32'(wr_total - w0), 32'(we && !io));
      if (!io) chk("strobe_addr", 32'(last_addr), 32'(a));
      if (mode != 1) begin
         Req = 1'b0;
         @(negedge Clock);
         chk("done_single", 32'(Done), 32'd0);
         chk("idle_after", 32'(Busy), 32'd0);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [8:0] ra;
   int         mism;

   initial begin
      // Preload RAM with random contents while reset is held.
      for (int i = 0; i < 512; i++) begin
         @(negedge Clock);
         bd_we = 1'b1; bd_addr = 9'(i); bd_data = $urandom;
         ref_mem[i] = bd_data;
      end
      @(negedge Clock);
      bd_we = 1'b0;

      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_rdata", RdData, 32'd0);
      chk("rst_outport", OutPort, 32'd0);
      chk("rst_strobes", {30'd0, RamRead, RamWrite}, 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      Reset_n = 1'b1;
      @(negedge Clock);

      // Write then read.
      access(1'b1, 9'h010, 32'hDEADBEEF, 0);
      access(1'b0, 9'h010, 32'h0, 0);

      // Back-to-back reads with Req held high.
      access(1'b1, 9'h000, 32'h11, 0);
      access(1'b1, 9'h001, 32'h22, 0);
      access(1'b1, 9'h002, 32'h33, 0);
      access(1'b1, 9'h003, 32'h44, 0);
      access(1'b0, 9'h000, 32'h0, 1);
      access(1'b0, 9'h001, 32'h0, 1);
      access(1'b0, 9'h002, 32'h0, 1);
      access(1'b0, 9'h003, 32'h0, 0);

      // Request while busy is ignored.
      access(1'b0, 9'h010, 32'h0, 2);
      chk("busy_ignore_ram020", ram[9'h020], ref_mem[9'h020]);

      // I/O port.
      access(1'b1, IO, 32'h0000A5A5, 0);
      InPort = 32'h12345678;
      access(1'b0, IO, 32'h0, 0);
      chk("io_ram_untouched", ram[IO], ref_mem[IO]);

      // Input stability after accept.
      access(1'b1, 9'h030, 32'h55, 0);
      chk("stable_ram030", ram[9'h030], 32'h55);

      // Highest RAM-backed address.
      access(1'b1, 9'h1FE, 32'hCAFEF00D, 0);
      access(1'b0, 9'h1FE, 32'h0, 0);

      // Reset in the middle of a read.
      Req = 1'b1; WrEn = 1'b0; Addr = 9'h055;
      @(posedge Clock); #1;
      Req = 1'b0;
      @(negedge Clock);
      chk("mid_read_strobe", 32'(RamRead), 32'd1);
      Reset_n = 1'b0;
      #1;
      chk("arst_ramread", 32'(RamRead), 32'd0);
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_done", 32'(Done), 32'd0);
      chk("arst_rdata", RdData, 32'd0);
      chk("arst_outport", OutPort, 32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      ref_rd = '0;
      ref_out = '0;
      @(negedge Clock);
      chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? IO : 9'($urandom);
         InPort = $urandom;
         access(1'($urandom), ra, $urandom, (i == 59) ? 0 : int'($urandom_range(0, 2)));
      end

      // Whole RAM image against the model.
      @(negedge Clock);
      mism = 0;
      for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) mism++;
      chk("ram_image", 32'(mism), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
